cascade_rom_arbiter: RTL and testbench

Shares the single synchronous cascade ROM between two requesters: port A (control FSM stage-header reads) and port B (stage evaluator classifier/feature reads). It issues at most one ROM read per cycle using round-robin arbitration, tracks in-flight reads in a tag pipeline and returns registered data with a one-cycle valid pulse to the originating port. It sits between the cascade ROM and both masters and replaces their direct ROM address muxing.

---
 rtl/cascade_rom_arbiter.sv | 108 ++++++++++
 tb/tb_cascade_rom_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous cascade ROM between two read ports.
// In-flight reads are tracked by a tag pipeline; data returns in issue order to the issuing port.
module cascade_rom_arbiter #(
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam int TAGS = ROM_LATENCY + 1;

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  port_e               last_grant;
  logic                grant_a;
  logic                grant_b;
  tag_t [TAGS-1:0]     tag_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_req && b_req) begin
      if (last_grant == PORT_B) grant_a = 1'b1;
      else                      grant_b = 1'b1;
    end else if (a_req) begin
      grant_a = 1'b1;
    end else if (b_req) begin
      grant_b = 1'b1;
    end
  end

  assign a_ack = grant_a;
  assign b_ack = grant_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      last_grant <= PORT_B;
    end else begin
      rom_en <= grant_a | grant_b;
      if (grant_a) begin
        rom_addr   <= a_addr;
        last_grant <= PORT_A;
      end else if (grant_b) begin
        rom_addr   <= b_addr;
        last_grant <= PORT_B;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_a | grant_b, port: (grant_b ? PORT_B : PORT_A)};
      for (int i = 1; i < TAGS; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // rom_data for a read is valid while its tag sits one stage before the end,
  // so it is registered there and appears together with the final tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (tag_q[TAGS-2].valid) begin
      if (tag_q[TAGS-2].port == PORT_A) a_rdata <= rom_data;
      else                              b_rdata <= rom_data;
    end
  end

  assign a_rvalid = tag_q[TAGS-1].valid && (tag_q[TAGS-1].port == PORT_A);
  assign b_rvalid = tag_q[TAGS-1].valid && (tag_q[TAGS-1].port == PORT_B);

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < TAGS; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

endmodule

// File: tb/tb_cascade_rom_arbiter.sv
// Bench for cascade_rom_arbiter: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_cascade_rom_arbiter;

  localparam int AW = 17;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ROM_LATENCY = 1 instance
  logic          a_req, b_req, a_ack, b_ack, a_rvalid, b_rvalid, rom_en, busy;
  logic [AW-1:0] a_addr, b_addr, rom_addr;
  logic [DW-1:0] a_rdata, b_rdata, rom_data;

  // ROM_LATENCY = 3 instance
  logic          a3_req, b3_req, a3_ack, b3_ack, a3_rvalid, b3_rvalid, rom_en3, busy3;
  logic [AW-1:0] a3_addr, b3_addr, rom_addr3;
  logic [DW-1:0] a3_rdata, b3_rdata, rom_data3;
  logic [AW-1:0] p1_addr3, p2_addr3;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] addr);
    if (addr == AW'(5)) return 32'h0000_1234;
    return {addr[14:0], addr} ^ 32'hC3A5_0F1E;
  endfunction

  // ROM models: the arbiter's rom_addr register is the ROM's address capture,
  // so a latency-L ROM adds L-1 further address stages.
  assign rom_data = rom_f(rom_addr);
  always @(posedge clk) begin
    p1_addr3 <= rom_addr3;
    p2_addr3 <= p1_addr3;
  end
  assign rom_data3 = rom_f(p2_addr3);

  cascade_rom_arbiter #(.ROM_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  cascade_rom_arbiter #(.ROM_LATENCY(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
    .clk(clk), .rst(rst),
    .a_req(a3_req), .a_addr(a3_addr), .a_ack(a3_ack), .a_rdata(a3_rdata), .a_rvalid(a3_rvalid),
    .b_req(b3_req), .b_addr(b3_addr), .b_ack(b3_ack), .b_rdata(b3_rdata), .b_rvalid(b3_rvalid),
    .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3), .busy(busy3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: port 0 = A, 1 = B; reads return ROM_LATENCY+1 = 2 cycles after ack.
  typedef struct {
    bit          port;
    logic [AW-1:0] addr;
    int          due;
  } rd_t;

  rd_t           q[$];
  int            cyc = 0;
  bit            m_last = 1'b1;
  bit            m_rom_en = 1'b0;
  logic [AW-1:0] m_rom_addr = '0;
  logic [DW-1:0] m_ardata = '0;
  logic [DW-1:0] m_brdata = '0;

  task automatic model_cycle();
    bit ga, gb, eav, ebv;
    if (rst) begin
      q.delete();
      m_last = 1'b1; m_rom_en = 1'b0; m_rom_addr = '0; m_ardata = '0; m_brdata = '0;
      check("rst rom_en",   64'(rom_en),   64'(0));
      check("rst rom_addr", 64'(rom_addr), 64'(0));
      check("rst a_rvalid", 64'(a_rvalid), 64'(0));
      check("rst b_rvalid", 64'(b_rvalid), 64'(0));
      check("rst a_rdata",  64'(a_rdata),  64'(0));
      check("rst b_rdata",  64'(b_rdata),  64'(0));
      check("rst busy",     64'(busy),     64'(0));
    end else begin
      ga = a_req && (!b_req || m_last);
      gb = b_req && (!a_req || !m_last);
      eav = 1'b0;
      ebv = 1'b0;
      check("model a_ack",    64'(a_ack),    64'(ga));
      check("model b_ack",    64'(b_ack),    64'(gb));
      check("model rom_en",   64'(rom_en),   64'(m_rom_en));
      check("model rom_addr", 64'(rom_addr), 64'(m_rom_addr));
      check("model busy",     64'(busy),     64'(q.size() != 0));
      if (q.size() != 0 && q[0].due == cyc) begin
        if (q[0].port) begin ebv = 1'b1; m_brdata = rom_f(q[0].addr); end
        else           begin eav = 1'b1; m_ardata = rom_f(q[0].addr); end
        void'(q.pop_front());
      end
      check("model a_rvalid", 64'(a_rvalid), 64'(eav));
      check("model b_rvalid", 64'(b_rvalid), 64'(ebv));
      check("model a_rdata",  64'(a_rdata),  64'(m_ardata));
      check("model b_rdata",  64'(b_rdata),  64'(m_brdata));
      if (ga || gb) begin
        q.push_back('{port: gb, addr: (gb ? b_addr : a_addr), due: cyc + 2});
        m_last = gb;
        m_rom_addr = gb ? b_addr : a_addr;
      end
      m_rom_en = ga || gb;
    end
    cyc++;
  endtask

  task automatic set_in(input logic ar, input int aa, input logic br, input int ba);
    a_req = ar; a_addr = AW'(aa); b_req = br; b_addr = AW'(ba);
  endtask

  task automatic step_neg();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic step_pos();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          a_req;
    int            a_addr;
    logic          b_req;
    int            b_addr;
    logic          e_aack, e_back, e_arv, e_brv, e_busy;
    logic [DW-1:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ar, input int aa, input logic br, input int ba,
                              input logic eaa, input logic eba, input logic earv,
                              input logic ebrv, input logic ebusy, input logic [DW-1:0] erd);
    vec_t v;
    v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_addr = ba;
    v.e_aack = eaa; v.e_back = eba; v.e_arv = earv; v.e_brv = ebrv; v.e_busy = ebusy;
    v.e_rdata = erd;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // contention from reset, withdrawal, then a lone-B burst
    vecs[0]  = mk(1, 10, 1, 20,  1, 0, 0, 0, 0, '0);
    vecs[1]  = mk(1, 10, 1, 20,  0, 1, 0, 0, 1, '0);
    vecs[2]  = mk(1, 10, 1, 20,  1, 0, 1, 0, 1, rom_f(10));
    vecs[3]  = mk(1, 10, 1, 20,  0, 1, 0, 1, 1, rom_f(20));
    vecs[4]  = mk(0, 0,  0, 0,   0, 0, 1, 0, 1, rom_f(10));
    vecs[5]  = mk(0, 0,  0, 0,   0, 0, 0, 1, 1, rom_f(20));
    vecs[6]  = mk(1, 40, 1, 30,  1, 0, 0, 0, 0, '0);
    vecs[7]  = mk(0, 0,  0, 0,   0, 0, 0, 0, 1, '0);
    vecs[8]  = mk(0, 0,  0, 0,   0, 0, 1, 0, 1, rom_f(40));
    vecs[9]  = mk(1, 50, 1, 60,  0, 1, 0, 0, 0, '0);
    vecs[10] = mk(0, 0,  0, 0,   0, 0, 0, 0, 1, '0);
    vecs[11] = mk(0, 0,  0, 0,   0, 0, 0, 1, 1, rom_f(60));
    vecs[12] = mk(0, 0,  0, 0,   0, 0, 0, 0, 0, '0);
    vecs[13] = mk(0, 0,  1, 100, 0, 1, 0, 0, 0, '0);
    vecs[14] = mk(0, 0,  1, 101, 0, 1, 0, 0, 1, '0);
    vecs[15] = mk(0, 0,  1, 102, 0, 1, 0, 1, 1, rom_f(100));
    vecs[16] = mk(0, 0,  1, 103, 0, 1, 0, 1, 1, rom_f(101));
    vecs[17] = mk(0, 0,  0, 0,   0, 0, 0, 1, 1, rom_f(102));
    vecs[18] = mk(0, 0,  0, 0,   0, 0, 0, 1, 1, rom_f(103));
    vecs[19] = mk(0, 0,  0, 0,   0, 0, 0, 0, 0, '0);

    set_in(0, 0, 0, 0);
    a3_req = 1'b0; a3_addr = '0; b3_req = 1'b0; b3_addr = '0;
    rst = 1'b1;
    step_neg();
    step_pos();
    rst = 1'b0;

    foreach (vecs[i]) begin
      set_in(vecs[i].a_req, vecs[i].a_addr, vecs[i].b_req, vecs[i].b_addr);
      step_neg();
      check($sformatf("vec%0d a_ack", i),    64'(a_ack),    64'(vecs[i].e_aack));
      check($sformatf("vec%0d b_ack", i),    64'(b_ack),    64'(vecs[i].e_back));
      check($sformatf("vec%0d a_rvalid", i), 64'(a_rvalid), 64'(vecs[i].e_arv));
      check($sformatf("vec%0d b_rvalid", i), 64'(b_rvalid), 64'(vecs[i].e_brv));
      check($sformatf("vec%0d busy", i),     64'(busy),     64'(vecs[i].e_busy));
      if (vecs[i].e_arv) check($sformatf("vec%0d a_rdata", i), 64'(a_rdata), 64'(vecs[i].e_rdata));
      if (vecs[i].e_brv) check($sformatf("vec%0d b_rdata", i), 64'(b_rdata), 64'(vecs[i].e_rdata));
      step_pos();
    end

    // single read of ROM[5]
    set_in(1, 5, 0, 0);
    step_neg();
    check("single a_ack", 64'(a_ack), 64'(1));
    step_pos();
    set_in(0, 0, 0, 0);
    step_neg();
    check("single rom_en", 64'(rom_en), 64'(1));
    check("single rom_addr", 64'(rom_addr), 64'(5));
    check("single early a_rvalid", 64'(a_rvalid), 64'(0));
    step_pos();
    step_neg();
    check("single a_rvalid", 64'(a_rvalid), 64'(1));
    check("single a_rdata", 64'(a_rdata), 64'(32'h0000_1234));
    check("single b_rvalid", 64'(b_rvalid), 64'(0));
    step_pos();
    step_neg();
    check("single a_rvalid drop", 64'(a_rvalid), 64'(0));
    step_pos();

    // latency sweep on the ROM_LATENCY=3 instance
    a3_req = 1'b1; a3_addr = AW'(7);
    for (int k = 0; k < 7; k++) begin
      step_neg();
      if (k == 0) check("lat3 a_ack", 64'(a3_ack), 64'(1));
      check($sformatf("lat3 a_rvalid c%0d", k), 64'(a3_rvalid), 64'(k == 4));
      check($sformatf("lat3 b_rvalid c%0d", k), 64'(b3_rvalid), 64'(0));
      if (k == 4) check("lat3 a_rdata", 64'(a3_rdata), 64'(rom_f(7)));
      step_pos();
      a3_req = 1'b0;
    end

    // reset while a read is in flight
    set_in(1, 200, 0, 0);
    step_neg();
    check("midrst a_ack", 64'(a_ack), 64'(1));
    step_pos();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    step_neg();
    check("midrst busy", 64'(busy), 64'(0));
    step_pos();
    rst = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step_neg();
      check($sformatf("midrst a_rvalid c%0d", k), 64'(a_rvalid), 64'(0));
      step_pos();
    end
    set_in(1, 300, 1, 301);
    step_neg();
    check("postrst a_ack", 64'(a_ack), 64'(1));
    check("postrst b_ack", 64'(b_ack), 64'(0));
    step_pos();

    // random traffic, including occasional resets, against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
      end else begin
        rst = 1'b0;
        set_in($urandom_range(0, 99) < 60, int'($urandom_range(0, 131071)),
               $urandom_range(0, 99) < 60, int'($urandom_range(0, 131071)));
      end
      step_neg();
      step_pos();
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (4) begin
      step_neg();
      step_pos();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
